// File: rtl/hex_display_pkg.sv
// Shared constants, state encoding and elaboration-time helpers for the
// calculator display sequencer (hex_display_ctrl and bcd_add3_stage).
package hex_display_pkg;

    // Digit code that the downstream 7-segment decoders render as all segments off.
    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Sequencer state encoding (IDLE, CONVERT, FORMAT).
    typedef logic [1:0] state_t;
    localparam state_t IDLE    = 2'd0;
    localparam state_t CONVERT = 2'd1;
    localparam state_t FORMAT  = 2'd2;

    // 10^n, used to derive the largest displayable value at elaboration time.
    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    // Counter width that can hold the value BIN_W itself.
    function automatic int unsigned cnt_width(input int unsigned bin_w);
        return 32'($clog2(bin_w + 1));
    endfunction

endpackage

// File: rtl/bcd_add3_stage.sv
// Double-dabble correction stage: adds 3 to every BCD nibble that is >= 5,
// so that the following left shift carries correctly into the next decade.
// Ports:
//   bcd_in   - packed BCD accumulator, [3:0] is the least-significant digit
//   bcd_out  - corrected accumulator, same layout
module bcd_add3_stage
    import hex_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic [4*NUM_DIGITS-1:0] bcd_out
);

    // Per-nibble conditional +3.
    always_comb begin
        bcd_out = bcd_in;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (bcd_in[4*i +: 4] >= 4'd5) begin
                bcd_out[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
            end
        end
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Calculator display sequencer: accepts a binary value over valid/ready,
// converts it to BCD one double-dabble step per cycle, applies overflow
// blanking (and optional leading-zero blanking), then registers one 4-bit
// digit code per display position.
// Optional feature macro: HEX_LZ_BLANK_EN (leading-zero blanking).
// Ports:
//   clk          - system clock, rising edge
//   resetn       - synchronous active-low reset
//   bin_in       - unsigned value to display
//   in_valid     - bin_in valid
//   in_ready     - block can accept a value (IDLE only)
//   digits_out   - digit codes, [3:0] is the least-significant digit
//   digits_valid - one-cycle pulse when digits_out updates
//   overflow     - last accepted value exceeded 10^NUM_DIGITS-1
//   busy         - conversion in progress
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BIN_W      = 14
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [BIN_W-1:0]        bin_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic                    digits_valid,
    output logic                    overflow,
    output logic                    busy
);

    localparam int unsigned DW = 4 * NUM_DIGITS;
    localparam int unsigned CW = cnt_width(BIN_W);
    localparam logic [63:0] MAX_VAL   = pow10(NUM_DIGITS) - 64'd1;
    localparam logic [DW-1:0] ALL_BLANK = {NUM_DIGITS{BLANK_CODE}};

    state_t          state_q,    state_d;
    logic [BIN_W-1:0] bin_q,     bin_d;
    logic [DW-1:0]   bcd_q,      bcd_d;
    logic [CW-1:0]   cnt_q,      cnt_d;
    logic            ovf_pend_q, ovf_pend_d;
    logic [DW-1:0]   digits_q,   digits_d;
    logic            valid_q,    valid_d;
    logic            overflow_q, overflow_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q,     busy_d;

    logic [DW-1:0]   bcd_adj;
    logic [DW-1:0]   shown;

    bcd_add3_stage #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_add3 (
        .bcd_in  (bcd_q),
        .bcd_out (bcd_adj)
    );

    // Display formatting of the finished BCD value.
`ifdef HEX_LZ_BLANK_EN
    logic leading;
    always_comb begin
        shown   = bcd_q;
        leading = 1'b1;
        // Blank from the MSD down while every digit so far is zero; the LSD always shows.
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            if (leading && (bcd_q[4*i +: 4] == 4'd0)) begin
                shown[4*i +: 4] = BLANK_CODE;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    always_comb begin
        shown = bcd_q;
    end
`endif

    // Next-state and datapath.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        digits_d   = digits_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    bin_d      = bin_in;
                    bcd_d      = '0;
                    cnt_d      = CW'(BIN_W);
                    ovf_pend_d = (64'(bin_in) > MAX_VAL);
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                // Correct then shift {bcd, bin} left; BCD carry past the MSD is dropped.
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FORMAT;
                end
            end
            FORMAT: begin
                digits_d   = ovf_pend_q ? ALL_BLANK : shown;
                overflow_d = ovf_pend_q;
                valid_d    = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d == CONVERT);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= IDLE;
            bin_q          <= '0;
            bcd_q          <= '0;
            cnt_q          <= '0;
            ovf_pend_q     <= 1'b0;
            digits_q       <= ALL_BLANK;
            digits_q[3:0]  <= 4'h0;
            valid_q        <= 1'b0;
            overflow_q     <= 1'b0;
            in_ready_q     <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            digits_q   <= digits_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign digits_out   = digits_q;
    assign digits_valid = valid_q;
    assign overflow     = overflow_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl (NUM_DIGITS=4, BIN_W=14).
// The driver pushes hand-computed expected digits on each accept; the
// monitor pops and compares on every digits_valid pulse.
module tb_hex_display_ctrl;

    localparam int unsigned ND  = 4;
    localparam int unsigned BW  = 14;
    localparam int          LAT = 15;

    logic            clk;
    logic            resetn;
    logic [BW-1:0]   bin_in;
    logic            in_valid;
    logic            in_ready;
    logic [4*ND-1:0] digits_out;
    logic            digits_valid;
    logic            overflow;
    logic            busy;

    hex_display_ctrl #(
        .NUM_DIGITS (ND),
        .BIN_W      (BW)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .bin_in       (bin_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .digits_out   (digits_out),
        .digits_valid (digits_valid),
        .overflow     (overflow),
        .busy         (busy)
    );

    typedef struct {
        logic [15:0] d;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every digits_valid pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (digits_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'(digits_out), 32'hDEAD);
            end else begin
                mon_e = sb.pop_front();
                chk("digits", 32'(digits_out), 32'(mon_e.d));
                chk("overflow", 32'(overflow), 32'(mon_e.ovf));
                chk("latency", 32'(cyc - mon_e.acc), 32'(LAT));
            end
        end
    end

    function automatic logic [15:0] pick(input logic [15:0] e_lz, input logic [15:0] e_nolz);
`ifdef HEX_LZ_BLANK_EN
        return e_lz;
`else
        return e_nolz;
`endif
    endfunction

    task automatic wait_ready();
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Present a value (called at a negedge), wait for accept, push expectation.
    task automatic send(input logic [BW-1:0] v, input logic [15:0] e_lz,
                        input logic [15:0] e_nolz, input logic ovf);
        exp_t e;
        bin_in   = v;
        in_valid = 1'b1;
        wait_ready();
        e.d   = pick(e_lz, e_nolz);
        e.ovf = ovf;
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_digits"},   32'(digits_out),   32'hFFF0);
        chk({tag, "_ready"},    32'(in_ready),     32'd1);
        chk({tag, "_overflow"}, 32'(overflow),     32'd0);
        chk({tag, "_valid"},    32'(digits_valid), 32'd0);
        chk({tag, "_busy"},     32'(busy),         32'd0);
    endtask

    initial begin
        exp_t e;
        int   lowcnt;
        resetn   = 1'b0;
        in_valid = 1'b0;
        bin_in   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk_reset_state("reset");

        send(14'd1234,  16'h1234, 16'h1234, 1'b0);
        send(14'd42,    16'hFF42, 16'h0042, 1'b0);
        send(14'd0,     16'hFFF0, 16'h0000, 1'b0);
        send(14'd9999,  16'h9999, 16'h9999, 1'b0);
        send(14'd10000, 16'hFFFF, 16'hFFFF, 1'b1);
        send(14'd16383, 16'hFFFF, 16'hFFFF, 1'b1);
        send(14'd7,     16'hFFF7, 16'h0007, 1'b0);
        send(14'd90,    16'hFF90, 16'h0090, 1'b0);
        send(14'd1005,  16'h1005, 16'h1005, 1'b0);

        // in_valid held through CONVERT: only 555 converts, 777 waits for IDLE.
        bin_in   = 14'd555;
        in_valid = 1'b1;
        wait_ready();
        e.d = pick(16'hF555, 16'h0555); e.ovf = 1'b0; e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bin_in = 14'd777;
        lowcnt = 0;
        while (in_ready !== 1'b1 && lowcnt < 100) begin
            if (lowcnt == 3) chk("busy_mid", 32'(busy), 32'd1);
            lowcnt++;
            @(negedge clk);
        end
        chk("ready_low_cycles", 32'(lowcnt), 32'(LAT));
        e.d = pick(16'hF777, 16'h0777); e.ovf = 1'b0; e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        // Put the display in overflow so the reset check is meaningful.
        send(14'd10000, 16'hFFFF, 16'hFFFF, 1'b1);
        drain();
        chk("pre_reset_ovf", 32'(overflow), 32'd1);

        // Abort a conversion of 8888 with reset at its fifth cycle.
        bin_in   = 14'd8888;
        in_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk_reset_state("abort");
        repeat (20) @(negedge clk);
        chk("abort_quiet_digits", 32'(digits_out), 32'hFFF0);

        send(14'd8888, 16'h8888, 16'h8888, 1'b0);
        send(14'd305,  16'hF305, 16'h0305, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
Sequencer that feeds the per-digit 7-segment decoders of the calculator display. It accepts a binary result over a valid/ready handshake and converts it to BCD iteratively, one double-dabble step per cycle. It applies leading-zero blanking and overflow blanking, then registers one 4-bit digit code per display position. Codes 0..9 select a numeral; 4'hF is the blank code, which the decoders render as all segments off.

Parameters:
NUM_DIGITS, 4, number of display digits driven (1..8)
BIN_W, 14, width of the binary input; max displayable value is 10^NUM_DIGITS-1

Ports:
clk  in  1  system clock, all logic on its rising edge
resetn  in  1  synchronous reset, active-low
bin_in  in  BIN_W  unsigned value to display
in_valid  in  1  bin_in valid
in_ready  out  1  block can accept a value (high only in IDLE)
digits_out  out  4*NUM_DIGITS  digit codes; [3:0] is the least-significant digit
digits_valid  out  1  one-cycle pulse when digits_out updates
overflow  out  1  last accepted value exceeded 10^NUM_DIGITS-1
busy  out  1  conversion in progress

Behaviour:
- Reset: clk plus resetn low, synchronous. Outputs after reset:
  - digits_out = blanks with LSD 0 (display shows "0")
  - overflow = 0, digits_valid = 0, busy = 0, in_ready = 1
  - FSM in IDLE
- Reset mid-conversion aborts it; the value in progress is discarded and the outputs take their reset values.
- FSM states: IDLE, CONVERT, FORMAT.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, capture bin_in into the shift register, clear the BCD accumulator (4*NUM_DIGITS bits) and load the iteration counter with BIN_W.
  - Latch ovf_pending = (bin_in > 10^NUM_DIGITS-1), using a compile-time constant.
  - Go to CONVERT.
- CONVERT:
  - in_ready = 0, busy = 1.
  - Each cycle: add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by one. Decrement the counter.
  - When the counter reaches 1 (last step taken), go to FORMAT. CONVERT lasts exactly BIN_W cycles.
- FORMAT (one cycle):
  - Write digits_out, set overflow = ovf_pending and pulse digits_valid.
  - If ovf_pending, every digit = 4'hF. Otherwise apply blanking per the optional feature.
  - Return to IDLE.
- Latency: accept at edge k; digits_out and digits_valid are visible after edge k+BIN_W+1 (15 cycles with defaults). Next accept is possible at edge k+BIN_W+2.
- in_valid while busy is ignored; the source must hold it until ready. Nothing is buffered.
- digits_out and overflow hold their values between updates. BCD overflow beyond NUM_DIGITS is truncated; only ovf_pending defines validity.
- Inputs of 0 and exactly 10^NUM_DIGITS-1 are legal, non-overflow values.

Optional Feature:
HEX_LZ_BLANK_EN
- Defined: after conversion, each digit from the MSD downward is replaced by 4'hF while it and every higher digit equals 0. The LSD is never blanked, so 0 shows as a single "0".
- Undefined: all digits are shown, including leading zeros (e.g. "0042"). Overflow still blanks every digit.

Decomposition:
- Package hex_display_pkg holds:
  - BLANK_CODE = 4'hF
  - state enum {IDLE, CONVERT, FORMAT}
  - a constant function pow10(n) for the overflow limit
  - a function that computes the counter width from BIN_W
- One natural combinational sub-module, bcd_add3_stage: adds 3 to each nibble >= 5 across NUM_DIGITS nibbles. The controller instantiates it once in the CONVERT datapath.

Test Plan:
- Reset then idle (LZ on): digits_out = F,F,F,0; in_ready = 1; overflow = 0; no digits_valid.
- Accept 1234 → digits_valid pulses exactly 15 cycles after accept; digits_out = 1,2,3,4; overflow = 0.
- Accept 42: LZ on → F,F,4,2; LZ off → 0,0,4,2. Accept 0 (LZ on) → F,F,F,0.
- Boundaries: 9999 → 9,9,9,9 with overflow = 0. 10000 and 16383 → F,F,F,F with overflow = 1. Then 7 → F,F,F,7 with overflow cleared.
- Hold in_valid high with 555, then 777 during CONVERT → only 555 is converted; in_ready low for 15 cycles; 777 is accepted on the next IDLE cycle and displayed 15 cycles later.
- Assert resetn low at cycle 5 of converting 8888 → outputs return to reset values; no digits_valid pulse; in_ready = 1 the cycle after release.
